// File: rtl/ram_arbiter.sv
// Arbiter for the shared system RAM: the CPU is stalled via RDY at SYNC so the
// VGA renderer (read) and the UART loader (write) can take the RAM ports.
module ram_arbiter #(
  parameter int ADDR_W         = 11,
  parameter int DRAIN_TIMEOUT  = 64,
  parameter int UART_MAX_GRANT = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_enable,
  input  logic              cpu_sync,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  input  logic              cpu_we,
  output logic              cpu_ready,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_grant,
  output logic              vga_rvalid,
  input  logic              uart_req,
  input  logic [ADDR_W-1:0] uart_addr,
  input  logic [7:0]        uart_wdata,
  input  logic              uart_we,
  output logic              uart_grant,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic              drain_timeout,
  output logic              uart_overrun
);
  localparam int DW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam int UW = (UART_MAX_GRANT > 1) ? $clog2(UART_MAX_GRANT) : 1;
  localparam logic [DW-1:0] DMAX = DW'(DRAIN_TIMEOUT - 1);
  localparam logic [UW-1:0] UMAX = UW'(UART_MAX_GRANT - 1);

  typedef enum logic [2:0] {PARK, RUN, DRAIN, GNT_VGA, GNT_UART} state_t;

  state_t        state;
  state_t        pick;
  logic          pending;
  logic [DW-1:0] dcnt;
  logic [UW-1:0] ucnt;

  assign pending = vga_req | uart_req;
  assign pick    = vga_req ? GNT_VGA : GNT_UART;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= PARK;
      cpu_ready     <= 1'b0;
      vga_grant     <= 1'b0;
      uart_grant    <= 1'b0;
      vga_rvalid    <= 1'b0;
      drain_timeout <= 1'b0;
      uart_overrun  <= 1'b0;
      dcnt          <= '0;
      ucnt          <= '0;
    end else begin
      vga_rvalid <= vga_grant & vga_req;
      if (uart_we && !uart_grant) uart_overrun <= 1'b1;
      // counters restart whenever their state is (re)entered, then saturate
      if (state != DRAIN)   dcnt <= '0;
      else if (dcnt != DMAX) dcnt <= dcnt + 1'b1;
      if (state != GNT_UART) ucnt <= '0;
      else if (ucnt != UMAX)  ucnt <= ucnt + 1'b1;

      case (state)
        PARK: begin
          cpu_ready <= 1'b0;
          if (pending) begin
            state <= pick; vga_grant <= vga_req; uart_grant <= ~vga_req;
          end else if (cpu_enable) state <= RUN;
        end
        RUN: begin
          if (!cpu_enable) begin
            state <= PARK; cpu_ready <= 1'b0;
          end else if (!pending) cpu_ready <= 1'b1;
          else if (cpu_sync) begin
            state <= pick; vga_grant <= vga_req; uart_grant <= ~vga_req;
            cpu_ready <= 1'b0;
          end else begin
            state <= DRAIN; cpu_ready <= 1'b1;
          end
        end
        DRAIN: begin
          if (!cpu_enable) begin
            state <= PARK; cpu_ready <= 1'b0;
          end else if (!pending) state <= RUN;
          else if (cpu_sync || dcnt == DMAX) begin
            state <= pick; vga_grant <= vga_req; uart_grant <= ~vga_req;
            cpu_ready <= 1'b0;
            if (!cpu_sync) drain_timeout <= 1'b1;
          end
        end
        GNT_VGA: begin
          cpu_ready <= 1'b0;
          if (!vga_req) begin
            vga_grant <= 1'b0;
            if (!cpu_enable) state <= PARK;
            else if (uart_req) begin
              state <= GNT_UART; uart_grant <= 1'b1;
            end else state <= RUN;
          end
        end
        GNT_UART: begin
          cpu_ready <= 1'b0;
          if (!uart_req || (vga_req && ucnt == UMAX)) begin
            uart_grant <= 1'b0;
            if (!cpu_enable) state <= PARK;
            else if (vga_req) begin
              state <= GNT_VGA; vga_grant <= 1'b1;
            end else state <= RUN;
          end
        end
        default: begin
          state <= PARK; cpu_ready <= 1'b0;
          vga_grant <= 1'b0; uart_grant <= 1'b0;
        end
      endcase
    end
  end

  // RAM port muxes follow the registered state only
  always_comb begin
    ram_waddr = cpu_addr;
    ram_wdata = cpu_wdata;
    ram_we    = cpu_we & cpu_ready;
    ram_raddr = cpu_addr;
    case (state)
      GNT_VGA: begin
        ram_raddr = vga_addr;
        ram_we    = 1'b0;
      end
      GNT_UART: begin
        ram_waddr = uart_addr;
        ram_wdata = uart_wdata;
        ram_we    = uart_we & uart_grant;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: drain, forced grant, VGA/UART hand-off,
// UART max grant, overrun and asynchronous reset.
module tb_ram_arbiter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_enable, cpu_sync, cpu_we;
  logic [10:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ready;
  logic        vga_req;
  logic [10:0] vga_addr;
  logic        vga_grant, vga_rvalid;
  logic        uart_req, uart_we;
  logic [10:0] uart_addr;
  logic [7:0]  uart_wdata;
  logic        uart_grant;
  logic [10:0] ram_waddr, ram_raddr;
  logic [7:0]  ram_wdata;
  logic        ram_we, drain_timeout, uart_overrun;

  int n_cmp = 0;
  int n_err = 0;

  ram_arbiter dut (
    .clk(clk), .reset_n(reset_n), .cpu_enable(cpu_enable), .cpu_sync(cpu_sync),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_ready(cpu_ready),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_grant(vga_grant), .vga_rvalid(vga_rvalid),
    .uart_req(uart_req), .uart_addr(uart_addr), .uart_wdata(uart_wdata), .uart_we(uart_we),
    .uart_grant(uart_grant), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_raddr(ram_raddr), .drain_timeout(drain_timeout), .uart_overrun(uart_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; cpu_enable = 1'b1; cpu_sync = 1'b0; cpu_we = 1'b0;
    cpu_addr = 11'h123; cpu_wdata = 8'h55; vga_req = 1'b0; vga_addr = 11'h040;
    uart_req = 1'b0; uart_we = 1'b0; uart_addr = 11'h000; uart_wdata = 8'h00;
    #13;
    chk("rst_ready", cpu_ready, 0);
    chk("rst_vga_grant", vga_grant, 0);
    chk("rst_uart_grant", uart_grant, 0);
    chk("rst_rvalid", vga_rvalid, 0);
    chk("rst_flags", {drain_timeout, uart_overrun}, 0);

    // reset release: PARK -> RUN, RDY one cycle later
    tick(); reset_n = 1'b1;
    tick(); chk("run_ready_clk1", cpu_ready, 0);
    tick(); chk("run_ready_clk2", cpu_ready, 1);
    cpu_we = 1'b1; #1;
    chk("run_ram_we", ram_we, 1);
    chk("run_waddr", ram_waddr, 11'h123);
    chk("run_wdata", ram_wdata, 8'h55);
    chk("run_raddr", ram_raddr, 11'h123);
    cpu_we = 1'b0; #1;
    chk("run_ram_we_off", ram_we, 0);

    // VGA request, sync arrives after 5 clocks of drain
    vga_req = 1'b1;
    tick(5);
    chk("drain_ready", cpu_ready, 1);
    chk("drain_no_grant", vga_grant, 0);
    chk("drain_raddr_cpu", ram_raddr, 11'h123);
    cpu_sync = 1'b1;
    tick(); cpu_sync = 1'b0; cpu_we = 1'b1; #1;
    chk("sync_ready", cpu_ready, 0);
    chk("sync_vga_grant", vga_grant, 1);
    chk("sync_rvalid_early", vga_rvalid, 0);
    chk("vga_raddr", ram_raddr, 11'h040);
    chk("vga_we_blocked", ram_we, 0);
    tick(); chk("vga_rvalid", vga_rvalid, 1);
    chk("no_timeout_yet", drain_timeout, 0);
    cpu_we = 1'b0; vga_req = 1'b0;
    tick();
    chk("vga_drop_grant", vga_grant, 0);
    chk("vga_drop_ready", cpu_ready, 0);
    chk("vga_drop_rvalid", vga_rvalid, 0);
    tick(); chk("back_run_ready", cpu_ready, 1);

    // VGA request with no sync: forced grant after 64 drain clocks
    vga_req = 1'b1;
    tick(64);
    chk("to_not_yet_grant", vga_grant, 0);
    chk("to_not_yet_flag", drain_timeout, 0);
    chk("to_not_yet_ready", cpu_ready, 1);
    tick();
    chk("to_grant", vga_grant, 1);
    chk("to_flag", drain_timeout, 1);
    chk("to_ready", cpu_ready, 0);
    vga_req = 1'b0;
    tick(2); chk("to_back_run", cpu_ready, 1);

    // simultaneous VGA + UART: VGA, then UART, then RUN
    vga_req = 1'b1; uart_req = 1'b1; cpu_sync = 1'b1;
    tick(); cpu_sync = 1'b0;
    chk("both_vga_grant", vga_grant, 1);
    chk("both_uart_wait", uart_grant, 0);
    tick(2); vga_req = 1'b0;
    tick();
    chk("both_vga_off", vga_grant, 0);
    chk("both_uart_grant", uart_grant, 1);
    chk("both_ready", cpu_ready, 0);
    uart_addr = 11'h300; uart_wdata = 8'h3C; uart_we = 1'b1; #1;
    chk("uart_ram_we", ram_we, 1);
    chk("uart_waddr", ram_waddr, 11'h300);
    chk("uart_wdata", ram_wdata, 8'h3C);
    tick(); uart_we = 1'b0;
    chk("uart_no_overrun", uart_overrun, 0);
    uart_req = 1'b0;
    tick();
    chk("uart_off", uart_grant, 0);
    chk("uart_off_ready", cpu_ready, 0);
    tick(); chk("uart_back_run", cpu_ready, 1);

    // UART write without a grant is dropped and flagged
    uart_addr = 11'h200; uart_wdata = 8'hA9; uart_we = 1'b1; #1;
    chk("ovr_ram_we", ram_we, 0);
    chk("ovr_waddr_cpu", ram_waddr, 11'h123);
    tick(); uart_we = 1'b0;
    chk("ovr_flag", uart_overrun, 1);

    // UART grant pre-empted after 256 cycles while VGA waits
    uart_req = 1'b1; cpu_sync = 1'b1;
    tick(); cpu_sync = 1'b0; vga_req = 1'b1;
    chk("umax_grant", uart_grant, 1);
    tick(255);
    chk("umax_still_uart", uart_grant, 1);
    chk("umax_vga_wait", vga_grant, 0);
    tick();
    chk("umax_uart_off", uart_grant, 0);
    chk("umax_vga_on", vga_grant, 1);
    vga_req = 1'b0;
    tick();
    chk("umax_uart_back", uart_grant, 1);

    // async reset mid-grant, then stay parked with cpu_enable low
    #2 reset_n = 1'b0; #1;
    chk("arst_uart", uart_grant, 0);
    chk("arst_vga", vga_grant, 0);
    chk("arst_ready", cpu_ready, 0);
    chk("arst_flags", {drain_timeout, uart_overrun}, 0);
    uart_req = 1'b0; cpu_enable = 1'b0;
    tick(); reset_n = 1'b1;
    tick(2); cpu_we = 1'b1; #1;
    chk("park_ready", cpu_ready, 0);
    chk("park_we", ram_we, 0);
    cpu_enable = 1'b1;
    tick(2);
    chk("unpark_ready", cpu_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
